seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Scan scheduler for the 8-digit multiplexed 7-segment array. It owns a
//  double-buffered 8-entry BCD/dp register file and time-shares the common
//  segment bus between the digits on a prescaled tick. It also applies
//  leading-zero blanking and PWM brightness. Sits between counter/BCD logic
//  (writer side) and the board seg_data/seg_sel pins.
// PARAMETERS
//  CLK_DIV  1000  clk cycles per digit slot (>=8); prescaler counts 0..CLK_DIV-1
//  DIV_W    10    prescaler width; must satisfy 2**DIV_W >= CLK_DIV
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst        in   1  asynchronous, active-low reset
//  enable     in   1  1 = scan running; 0 = display dark, prescaler/index held
//  wr_en      in   1  write strobe into shadow bank, one entry per cycle
//  wr_addr    in   3  digit index, 0 = rightmost (seg_sel 8'b11111110)
//  wr_data    in   4  BCD value; 0-9 shown, 10-15 shown blank
//  wr_dp      in   1  decimal point for that digit
//  commit     in   1  pulse: copy shadow bank to active bank at next frame start
//  blank_en   in   1  1 = leading-zero suppression on
//  bright     in   3  brightness 0 (dimmest) .. 7 (full)
//  commit_ack out  1  one-cycle pulse when the copy happens
//  frame_strt out  1  one-cycle pulse when scan index wraps 7->0
//  seg_data   out  8  {a,b,c,d,e,f,g,dp}, active-high; '0' = 8'b11111100
//  seg_sel    out  8  active-low one-hot digit select
// BEHAVIOUR
//  Reset (rst=0, async): seg_data=0, seg_sel=8'hFF, prescaler=0, idx=0,
//   both banks=0, dp=0, commit_pend=0, commit_ack=0, frame_strt=0.
//  Prescaler: when enable=1, cnt increments and wraps at CLK_DIV-1.
//   tick = (cnt==CLK_DIV-1). On tick, idx <= idx+1 (mod 8).
//  frame_strt: pulses in the cycle after the tick that takes idx from 7 to 0.
//  Outputs are registered from the current cnt/idx/active bank, so they
//   have 1 clk of latency relative to cnt/idx.
//   drive = enable && (cnt < thr), with thr = max(1, ((bright+1)*CLK_DIV)>>3).
//   If drive: seg_sel = ~(8'b1<<idx) and seg_data = decode(digit[idx]) | dp[idx].
//   Otherwise: seg_sel = 8'hFF and seg_data = 0.
//   With bright=7 the digit is lit for the full slot.
//  Decode: uses the codebase table (1=01100000, 8=11111110, 9=11110110).
//   Values 10-15 decode to segments 0; the dp bit is still ORed in.
//  Blanking: when blank_en=1, digit k (k>=1) is blanked (segments 0, dp kept)
//   if active digit[k] and all digits above it are 0. Digit 0 is never blanked.
//  Shadow writes: a write on wr_en lands in the shadow entry at the next edge.
//   The active bank is never written directly.
//  Commit handshake: a commit pulse sets commit_pend.
//   On the tick where idx wraps 7->0 with commit_pend=1, the active bank is
//   loaded with the pre-edge shadow bank, commit_pend clears, and commit_ack
//   pulses in the next cycle. The new frame then starts with the new data,
//   so the display never tears.
//  Simultaneous events:
//   - commit while commit_pend=1: absorbed; one ack only.
//   - wr_en in the copy cycle: lands in shadow only; it is not in this copy.
//   - commit in the copy cycle: sets commit_pend again for the next frame.
//  enable=0: display dark, cnt and idx frozen, and no copy occurs.
//   Writes and commit_pend are still accepted. Resume continues from the
//   frozen cnt/idx.
//  Reset mid-frame: immediate dark outputs; pending commit lost; banks cleared.
// TESTING
//  T1 reset: rst=0 mid-scan -> same cycle seg_sel=FF, seg_data=00;
//     after release (CLK_DIV=8, bright=7) first lit sel=FE with data 11111100.
//  T2 write/commit: shadow d0=3, d1=7 + commit -> pre-wrap frames still show 0.
//     After frame_strt, sel=FE shows 11110010, sel=FD shows 11100000;
//     commit_ack pulses once.
//  T3 blanking: active 0,0,0,0,0,1,0,5 (d7..d0), blank_en=1 ->
//     d7..d3 segs 0, d2=01100000, d1=11111100, d0=10110110.
//  T4 brightness: CLK_DIV=8, bright=0 -> thr=1, so each digit is lit 1 of 8 clks.
//     bright=3 -> lit 4 of 8 clks; bright=7 -> lit 8 of 8.
//  T5 collisions: commit twice in one frame -> one ack.
//     wr_en d0=9 in the copy cycle -> not shown until the next commit.
//  T6 enable: enable=0 for 20 clks -> FF/00 throughout, idx unchanged;
//     re-enable -> scan resumes at the same digit.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Writer-side bus of the display scanner: shadow-bank writes and the commit handshake.
interface seg_scan_ctrl_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       commit;
    logic       commit_ack;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output wr_dp,
        output commit,
        input  commit_ack
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  wr_dp,
        input  commit,
        output commit_ack
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed 7-segment scanner with a double-buffered digit bank,
// tear-free commit at frame start, leading-zero blanking and PWM brightness.
module seg_scan_ctrl #(
    parameter int unsigned CLK_DIV = 1000,
    parameter int unsigned DIV_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              blank_en,
    input  logic [2:0]        bright,
    seg_scan_ctrl_if.slave    wr,
    output logic              frame_strt,
    output logic [7:0]        seg_data,
    output logic [7:0]        seg_sel
);

    localparam int unsigned           PW      = DIV_W + 4;
    localparam logic [DIV_W-1:0]      CNT_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0][3:0]   sh_data_q, sh_data_d;
    logic [7:0]        sh_dp_q, sh_dp_d;
    logic [7:0][3:0]   act_data_q, act_data_d;
    logic [7:0]        act_dp_q, act_dp_d;
    logic              pend_q, pend_d;
    logic              ack_q, ack_d;
    logic              frame_q, frame_d;
    logic [7:0]        seg_data_q, seg_data_d;
    logic [7:0]        seg_sel_q, seg_sel_d;

    logic              tick_c, wrap_c, copy_c;
    logic [PW-1:0]     prod_c, thr_c;
    logic              drive_c, nz_above_c, lz_c;

    // Segment pattern {a,b,c,d,e,f,g,dp}; codes 10-15 are shown blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'b1111_1100;
            4'd1:    s = 8'b0110_0000;
            4'd2:    s = 8'b1101_1010;
            4'd3:    s = 8'b1111_0010;
            4'd4:    s = 8'b0110_0110;
            4'd5:    s = 8'b1011_0110;
            4'd6:    s = 8'b1011_1110;
            4'd7:    s = 8'b1110_0000;
            4'd8:    s = 8'b1111_1110;
            4'd9:    s = 8'b1111_0110;
            default: s = 8'b0000_0000;
        endcase
        return s;
    endfunction

    // Brightness threshold and blanking for the digit currently in its slot.
    always_comb begin
        prod_c = PW'({1'b0, bright} + 4'd1) * PW'(CLK_DIV);
        thr_c  = prod_c >> 3;
        if (thr_c == '0) begin
            thr_c = PW'(1);
        end
        drive_c = enable && (PW'(cnt_q) < thr_c);

        nz_above_c = 1'b0;
        for (int unsigned j = 0; j < 8; j++) begin
            if ((3'(j) >= idx_q) && (act_data_q[j] != 4'd0)) begin
                nz_above_c = 1'b1;
            end
        end
        lz_c = blank_en && (idx_q != 3'd0) && !nz_above_c;
    end

    // Next-state: prescaler, scan index, banks, commit handshake, pin drive.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        pend_d     = pend_q;
        seg_sel_d  = 8'hFF;
        seg_data_d = 8'h00;

        tick_c = enable && (cnt_q == CNT_MAX);
        wrap_c = tick_c && (idx_q == 3'd7);
        copy_c = wrap_c && pend_q;

        if (enable) begin
            cnt_d = tick_c ? '0 : cnt_q + DIV_W'(1);
            if (tick_c) begin
                idx_d = idx_q + 3'd1;
            end
        end

        // The copy takes the pre-edge shadow, so a same-cycle write misses it.
        if (copy_c) begin
            act_data_d = sh_data_q;
            act_dp_d   = sh_dp_q;
            pend_d     = wr.commit;
        end else begin
            pend_d     = pend_q | wr.commit;
        end

        if (wr.wr_en) begin
            sh_data_d[wr.wr_addr] = wr.wr_data;
            sh_dp_d[wr.wr_addr]   = wr.wr_dp;
        end

        frame_d = wrap_c;
        ack_d   = copy_c;

        if (drive_c) begin
            seg_sel_d  = ~(8'(1) << idx_q);
            seg_data_d = (lz_c ? 8'h00 : seg_decode(act_data_q[idx_q]))
                         | {7'b0, act_dp_q[idx_q]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            frame_q    <= 1'b0;
            seg_data_q <= 8'h00;
            seg_sel_q  <= 8'hFF;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            frame_q    <= frame_d;
            seg_data_q <= seg_data_d;
            seg_sel_q  <= seg_sel_d;
        end
    end

    assign seg_data      = seg_data_q;
    assign seg_sel       = seg_sel_q;
    assign frame_strt    = frame_q;
    assign wr.commit_ack = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-level reference model predicts
// every registered output; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned DIV_W   = 3;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] data;
        logic       fs;
        logic       ack;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       blank_en;
    logic [2:0] bright;
    logic       frame_strt;
    logic [7:0] seg_data;
    logic [7:0] seg_sel;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .blank_en   (blank_en),
        .bright     (bright),
        .wr         (bus.slave),
        .frame_strt (frame_strt),
        .seg_data   (seg_data),
        .seg_sel    (seg_sel)
    );

    always #5 clk = ~clk;

    exp_t       q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;

    // Reference model state: slot counter, digit position, two banks, pending flag.
    int         m_cnt, m_idx, m_pend;
    int         sh_v[8], sh_p[8], ac_v[8], ac_p[8];
    logic [7:0] seg_tab[16];

    logic [7:0] seen[8];
    logic [7:0] last_sel;
    int         lit_cnt = 0;
    int         ack_cnt = 0;

    function automatic exp_t dark();
        exp_t e;
        e.sel  = 8'hFF;
        e.data = 8'h00;
        e.fs   = 1'b0;
        e.ack  = 1'b0;
        return e;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   thr;
        bit   blank;
        e   = dark();
        thr = ((int'(bright) + 1) * int'(CLK_DIV)) / 8;
        if (thr < 1) thr = 1;
        if (enable && m_cnt < thr) begin
            blank = blank_en && (m_idx > 0);
            for (int j = m_idx; j < 8; j++) if (ac_v[j] != 0) blank = 0;
            e.sel  = 8'hFF ^ (8'h01 << m_idx);
            e.data = (blank ? 8'h00 : seg_tab[ac_v[m_idx]]) | 8'(ac_p[m_idx]);
        end
        e.fs  = enable && (m_cnt == int'(CLK_DIV) - 1) && (m_idx == 7);
        e.ack = e.fs && (m_pend != 0);
        return e;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_pend = 0;
        for (int i = 0; i < 8; i++) begin
            sh_v[i] = 0; sh_p[i] = 0; ac_v[i] = 0; ac_p[i] = 0;
        end
    endtask

    task automatic model_step();
        bit wrap;
        wrap = enable && (m_cnt == int'(CLK_DIV) - 1) && (m_idx == 7);
        if (wrap && m_pend != 0) begin
            ac_v   = sh_v;
            ac_p   = sh_p;
            m_pend = bus.commit ? 1 : 0;
        end else if (bus.commit) begin
            m_pend = 1;
        end
        if (bus.wr_en) begin
            sh_v[bus.wr_addr] = int'(bus.wr_data);
            sh_p[bus.wr_addr] = bus.wr_dp ? 1 : 0;
        end
        if (enable) begin
            if (m_cnt == int'(CLK_DIV) - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Called one time unit after a rising edge with the cycle's inputs applied.
    task automatic step();
        q.push_back(model_out());
        model_step();
        @(posedge clk);
        #1;
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write(input int a, input int d, input bit dp);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = 4'(d);
        bus.wr_dp   = dp;
        step();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Asynchronous reset mid-cycle: dark immediately, then release after four edges.
    task automatic do_reset();
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;
        rst = 1'b0;
        #1;
        check("async_reset_dark", {seg_sel, seg_data}, {8'hFF, 8'h00});
        q.delete();
        q.push_back(dark());
        q.push_back(dark());
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            q.push_back(dark());
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            total++;
            if ({seg_sel, seg_data, frame_strt, bus.commit_ack} !== mon_e) begin
                bad++;
                $display("FAIL scoreboard t=%0t: got sel=%h data=%h fs=%b ack=%b, required sel=%h data=%h fs=%b ack=%b",
                         $time, seg_sel, seg_data, frame_strt, bus.commit_ack,
                         mon_e.sel, mon_e.data, mon_e.fs, mon_e.ack);
            end
        end
        if (seg_sel != 8'hFF) begin
            lit_cnt++;
            last_sel = seg_sel;
            for (int i = 0; i < 8; i++) if (!seg_sel[i]) seen[i] = seg_data;
        end
        if (bus.commit_ack) ack_cnt++;
    end

    task automatic bright_test(input int b, input int want);
        int l0;
        bright = 3'(b);
        step();
        l0 = lit_cnt;
        run(64);
        check($sformatf("lit_cycles_bright%0d", b), 32'(lit_cnt - l0), 32'(want));
    endtask

    initial begin
        int a0, l0, n;
        logic [7:0] s0;

        seg_tab[0]  = 8'hFC; seg_tab[1]  = 8'h60; seg_tab[2]  = 8'hDA; seg_tab[3]  = 8'hF2;
        seg_tab[4]  = 8'h66; seg_tab[5]  = 8'hB6; seg_tab[6]  = 8'hBE; seg_tab[7]  = 8'hE0;
        seg_tab[8]  = 8'hFE; seg_tab[9]  = 8'hF6;
        for (int i = 10; i < 16; i++) seg_tab[i] = 8'h00;
        for (int i = 0; i < 8; i++) seen[i] = 8'h00;
        last_sel = 8'hFF;

        rst = 1'b0; enable = 1'b0; blank_en = 1'b0; bright = 3'd7;
        bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 4'd0; bus.wr_dp = 1'b0; bus.commit = 1'b0;
        model_reset();

        @(posedge clk);
        #1;
        do_reset();
        enable = 1'b1;

        // Empty banks, then a mid-scan reset: first lit slot after release is digit 0.
        run(70);
        check("t1_digit0_zero", 32'(seen[0]), 32'h00FC);
        do_reset();
        last_sel = 8'h00;
        step();
        step();
        check("t1_first_sel_after_reset", 32'(last_sel), 32'h00FE);
        check("t1_first_data_after_reset", 32'(seen[0]), 32'h00FC);

        // Shadow write and commit; display switches only at the next frame.
        write(0, 3, 1'b0);
        write(1, 7, 1'b0);
        bus.commit = 1'b1;
        step();
        a0 = ack_cnt;
        run(140);
        check("t2_digit0", 32'(seen[0]), 32'h00F2);
        check("t2_digit1", 32'(seen[1]), 32'h00E0);
        check("t2_ack_count", 32'(ack_cnt - a0), 32'd1);

        // Leading-zero blanking over active 0,0,0,0,0,1,0,5.
        write(0, 5, 1'b0);
        write(1, 0, 1'b0);
        write(2, 1, 1'b0);
        for (int k = 3; k < 8; k++) write(k, 0, 1'b0);
        blank_en   = 1'b1;
        bus.commit = 1'b1;
        step();
        run(140);
        for (int k = 3; k < 8; k++) check($sformatf("t3_blank_d%0d", k), 32'(seen[k]), 32'h0);
        check("t3_d2", 32'(seen[2]), 32'h0060);
        check("t3_d1", 32'(seen[1]), 32'h00FC);
        check("t3_d0", 32'(seen[0]), 32'h00B6);

        // PWM duty per slot.
        blank_en = 1'b0;
        bright_test(0, 8);
        bright_test(3, 32);
        bright_test(7, 64);

        // Double commit in one frame and a write landing in the copy cycle.
        write(0, 4, 1'b0);
        n = 0;
        while (!(m_idx == 0 && m_cnt == 1) && n < 200) begin step(); n++; end
        check("t5_align_timeout", 32'(n < 200), 32'd1);
        bus.commit = 1'b1;
        step();
        run(2);
        bus.commit = 1'b1;
        step();
        a0 = ack_cnt;
        n = 0;
        while (!(m_pend != 0 && m_idx == 7 && m_cnt == int'(CLK_DIV) - 1) && n < 200) begin step(); n++; end
        check("t5_copy_timeout", 32'(n < 200), 32'd1);
        write(0, 9, 1'b0);
        run(140);
        check("t5_ack_count", 32'(ack_cnt - a0), 32'd1);
        check("t5_copy_excludes_write", 32'(seen[0]), 32'h0066);

        // Disable mid-slot: dark, frozen, then resume on the same digit.
        n = 0;
        while (m_cnt != 3 && n < 50) begin step(); n++; end
        check("t6_align_timeout", 32'(n < 50), 32'd1);
        enable = 1'b0;
        step();
        l0 = lit_cnt;
        s0 = last_sel;
        run(19);
        check("t6_dark_while_disabled", 32'(lit_cnt - l0), 32'd0);
        enable = 1'b1;
        step();
        step();
        check("t6_resume_same_digit", 32'(last_sel), 32'(s0));

        // Randomized traffic with one asynchronous reset in the middle.
        for (int it = 0; it < 1500; it++) begin
            if (it == 700) do_reset();
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) bright = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) blank_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 3'($urandom_range(0, 7));
                bus.wr_data = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
                bus.wr_dp   = ($urandom_range(0, 7) == 0);
            end
            bus.commit = ($urandom_range(0, 19) == 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
